// File: rtl/bram_port_pkg.sv
// Shared types and constants for the BRAM port adapter and its response FIFO.
package bram_port_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned BYTE_OFS_W = 2;
   localparam int unsigned DATA_W     = 32;

   typedef struct packed {
      logic              write;
      logic [DATA_W-1:0] rdata;
   } rsp_entry_t;

endpackage

// File: rtl/bram_port_rsp_fifo.sv
// Synchronous response FIFO with a registered head entry.
// The head holds its last value while empty and clears only on reset.
module bram_port_rsp_fifo
   import bram_port_pkg::*;
#(
   parameter  int unsigned DEPTH = 3,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             push,
   input  rsp_entry_t       push_data,
   input  logic             pop,
   output rsp_entry_t       head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rsp_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [CNT_W-1:0] count_nxt;
   rsp_entry_t       head_nxt;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(DEPTH));
   assign do_push    = push & ~full;
   assign do_pop     = pop & ~empty;
   assign rd_ptr_nxt = do_pop ? ptr_inc(rd_ptr) : rd_ptr;

   // Next count and next head; a push into an otherwise-empty FIFO becomes the head directly.
   always_comb begin
      count_nxt = count;
      head_nxt  = head;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
      if (count_nxt != '0) begin
         if (do_push && (count_nxt == CNT_W'(1))) begin
            head_nxt = push_data;
         end else begin
            head_nxt = mem[rd_ptr_nxt];
         end
      end
   end

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers, count and head register.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         head   <= head_nxt;
      end
   end

   // Upstream admission control must never let a push reach a full FIFO.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset_i) !(push && full));

endmodule

// File: rtl/bram_port_adapter.sv
// Valid/ready request stream to single BRAM port adapter with in-order response FIFO.
// Optional macro BRAM_PORT_ADAPTER_OUTREG_EN adds a register stage on the BRAM read data.
module bram_port_adapter
   import bram_port_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned RSP_DEPTH  = 3
) (
   input  logic                             clk,
   input  logic                             reset_i,
   input  logic                             req_valid_i,
   output logic                             req_ready_o,
   input  logic [WORD_BYTES-1:0]            req_we_i,
   input  logic [ADDR_WIDTH+BYTE_OFS_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0]                req_wdata_i,
   output logic                             rsp_valid_o,
   input  logic                             rsp_ready_i,
   output logic [DATA_W-1:0]                rsp_rdata_o,
   output logic                             rsp_write_o,
   output logic                             bram_clken_o,
   output logic [ADDR_WIDTH-1:0]            bram_addr_o,
   output logic [WORD_BYTES-1:0]            bram_we_o,
   output logic [DATA_W-1:0]                bram_wdata_o,
   input  logic [DATA_W-1:0]                bram_rdata_i
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   logic             accept;
   logic             p1_valid;
   logic             p1_write;
   rsp_entry_t       p1_entry;
   logic             fifo_push;
   rsp_entry_t       fifo_push_data;
   rsp_entry_t       fifo_head;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [OCC_W-1:0] occupancy;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^req_addr_i[BYTE_OFS_W-1:0];

   // BRAM is driven straight from the request in the accept cycle.
   assign accept       = req_valid_i & req_ready_o;
   assign bram_clken_o = accept;
   assign bram_we_o    = accept ? req_we_i : '0;
   assign bram_addr_o  = req_addr_i[ADDR_WIDTH+BYTE_OFS_W-1:BYTE_OFS_W];
   assign bram_wdata_o = req_wdata_i;

   // p1 tracks the access whose read data is on bram_rdata_i this cycle.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         p1_valid <= 1'b0;
         p1_write <= 1'b0;
      end else begin
         p1_valid <= accept;
         p1_write <= |req_we_i;
      end
   end

   assign p1_entry.write = p1_write;
   assign p1_entry.rdata = p1_write ? '0 : bram_rdata_i;

`ifdef BRAM_PORT_ADAPTER_OUTREG_EN
   logic       p2_valid;
   rsp_entry_t p2_entry;

   // p2 registers the RAM output before it enters the FIFO.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         p2_valid <= 1'b0;
         p2_entry <= '0;
      end else begin
         p2_valid <= p1_valid;
         p2_entry <= p1_entry;
      end
   end

   assign fifo_push      = p2_valid;
   assign fifo_push_data = p2_entry;
   assign occupancy      = OCC_W'(fifo_count) + OCC_W'(p1_valid) + OCC_W'(p2_valid);
`else
   assign fifo_push      = p1_valid;
   assign fifo_push_data = p1_entry;
   assign occupancy      = OCC_W'(fifo_count) + OCC_W'(p1_valid);
`endif

   // Admit a request only if every in-flight response is guaranteed a FIFO slot.
   assign req_ready_o = ~reset_i & (occupancy < OCC_W'(RSP_DEPTH));

   bram_port_rsp_fifo #(
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .reset_i   (reset_i),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (rsp_valid_o & rsp_ready_i),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign rsp_valid_o = ~fifo_empty;
   assign rsp_rdata_o = fifo_head.rdata;
   assign rsp_write_o = fifo_head.write;

endmodule

// File: tb/tb_bram_port_adapter.sv
// Scoreboard bench for bram_port_adapter with a behavioural BRAM and reference memory.
module tb_bram_port_adapter;

   localparam int unsigned AW     = 13;
   localparam int unsigned AW2    = AW + 2;
   localparam int unsigned NWORDS = 1 << AW;
`ifdef BRAM_PORT_ADAPTER_OUTREG_EN
   localparam int unsigned DEPTH = 4;
   localparam int          LAT   = 3;
`else
   localparam int unsigned DEPTH = 3;
   localparam int          LAT   = 2;
`endif

   logic           clk = 1'b0;
   logic           reset_i;
   logic           req_valid;
   logic           req_ready;
   logic [3:0]     req_we;
   logic [AW2-1:0] req_addr;
   logic [31:0]    req_wdata;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [31:0]    rsp_rdata;
   logic           rsp_write;
   logic           bram_clken;
   logic [AW-1:0]  bram_addr;
   logic [3:0]     bram_we;
   logic [31:0]    bram_wdata;
   logic [31:0]    bram_rdata = 32'h0;

   typedef struct {
      logic        write;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   int          acc_cyc_q[$];
   int          pop_cyc_q[$];
   logic [31:0] bram_mem [NWORDS] = '{default: 32'h0};
   logic [31:0] ref_mem  [NWORDS] = '{default: 32'h0};
   logic [31:0] bram_tmp;
   logic [31:0] last_rdata = 32'h0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          rdy_mode = 1;

   bram_port_adapter #(
      .ADDR_WIDTH (AW),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_rdata_o  (rsp_rdata),
      .rsp_write_o  (rsp_write),
      .bram_clken_o (bram_clken),
      .bram_addr_o  (bram_addr),
      .bram_we_o    (bram_we),
      .bram_wdata_o (bram_wdata),
      .bram_rdata_i (bram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural block RAM: byte enables, one-cycle read latency.
   always @(posedge clk) begin
      if (bram_clken) begin
         bram_tmp = bram_mem[bram_addr];
         for (int b = 0; b < 4; b++) begin
            if (bram_we[b]) bram_tmp[8*b +: 8] = bram_wdata[8*b +: 8];
         end
         bram_mem[bram_addr] <= bram_tmp;
         bram_rdata          <= bram_tmp;
      end
   end

   // Response-side ready: 0 = held low, 1 = held high, 2 = random.
   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       rsp_ready = 1'b0;
         1:       rsp_ready = 1'b1;
         default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: an accepted request immediately updates memory and queues its response.
   task automatic model_accept(input logic [3:0] we, input logic [AW2-1:0] addr, input logic [31:0] wd);
      int   w;
      exp_t e;
      w = int'(addr >> 2);
      if (we != 4'h0) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
         end
         e.write = 1'b1;
         e.rdata = 32'h0;
      end else begin
         e.write = 1'b0;
         e.rdata = ref_mem[w];
      end
      exp_q.push_back(e);
      acc_cyc_q.push_back(cyc);
   endtask

   // Monitor: pops the scoreboard whenever a response is consumed.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_i) begin
         check("occupancy_bound", 32'(exp_q.size() <= int'(DEPTH)), 32'd1);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got write=%0d rdata=0x%08h, expected no response (cycle %0d)",
                        rsp_write, rsp_rdata, cyc);
            end else begin
               e = exp_q.pop_front();
               check("rsp_write", 32'(rsp_write), 32'(e.write));
               check("rsp_rdata", rsp_rdata, e.rdata);
               pop_cyc_q.push_back(cyc);
               last_rdata = rsp_rdata;
            end
         end
      end
   end

   // Present one request; entered and left at posedge+1.
   task automatic issue(input logic [3:0] we, input logic [AW2-1:0] addr, input logic [31:0] wd,
                        output int waits);
      waits     = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      forever begin
         @(negedge clk);
         if (req_ready) begin
            model_accept(we, addr, wd);
            break;
         end
         waits++;
         if (waits > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got no accept after %0d cycles, expected accept", waits);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got %0d responses outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int             waits;
      int             n_acc;
      logic [3:0]     rwe;
      logic [AW2-1:0] raddr;
      int             gap;

      reset_i   = 1'b1;
      req_valid = 1'b0;
      req_we    = 4'h0;
      req_addr  = '0;
      req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_clken", 32'(bram_clken), 32'd0);
      check("reset_bram_we", 32'(bram_we), 32'd0);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_rsp_rdata", rsp_rdata, 32'd0);
      check("idle_rsp_write", 32'(rsp_write), 32'd0);
      @(posedge clk);
      #1;

      // Write then read of the same word, and byte-merge with an unaligned address.
      issue(4'hF, AW2'(16'h0010), 32'hDEADBEEF, waits);
      issue(4'h0, AW2'(16'h0010), 32'h0, waits);
      issue(4'hF, AW2'(16'h0040), 32'h11223344, waits);
      issue(4'h8, AW2'(16'h0040), 32'hAA000000, waits);
      issue(4'h0, AW2'(16'h0043), 32'h0, waits);
      wait_drain("drain_directed");

      // Back-to-back reads of words 0..15: no stalls, gap-free responses at fixed latency.
      acc_cyc_q.delete();
      pop_cyc_q.delete();
      for (int i = 0; i < 16; i++) begin
         issue(4'h0, AW2'(i * 4), $urandom, waits);
         check("b2b_no_stall", 32'(waits), 32'd0);
      end
      wait_drain("drain_b2b");
      check("b2b_rsp_count", 32'(pop_cyc_q.size()), 32'd16);
      if (pop_cyc_q.size() == 16 && acc_cyc_q.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            check("b2b_rsp_cycle", 32'(pop_cyc_q[i]), 32'(acc_cyc_q[0] + LAT + i));
         end
      end
      @(negedge clk);
      check("empty_rsp_valid", 32'(rsp_valid), 32'd0);
      check("empty_rdata_hold", rsp_rdata, last_rdata);
      @(posedge clk);
      #1;

      // Response back-pressure: exactly DEPTH accepts, then drain and resume.
      rdy_mode  = 0;
      @(posedge clk);
      #1;
      n_acc     = 0;
      req_valid = 1'b1;
      req_we    = 4'h0;
      req_addr  = AW2'(16'h0010);
      repeat (10) begin
         @(negedge clk);
         if (req_ready) begin
            model_accept(req_we, req_addr, req_wdata);
            n_acc++;
         end
         @(posedge clk);
         #1;
         req_addr = AW2'(16'h0040 + 4 * n_acc);
      end
      check("bp_accepts", 32'(n_acc), 32'(DEPTH));
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rdy_mode = 1;
      n_acc    = 0;
      for (int i = 0; i < 30 && n_acc < 2; i++) begin
         @(negedge clk);
         if (req_ready) begin
            model_accept(req_we, req_addr, req_wdata);
            n_acc++;
         end
         @(posedge clk);
         #1;
         req_addr = AW2'(16'h0010 + 4 * n_acc);
      end
      req_valid = 1'b0;
      check("bp_resume", 32'(n_acc), 32'd2);
      wait_drain("drain_bp");

      // Reset with two reads in flight: everything in flight is dropped.
      rdy_mode = 0;
      @(posedge clk);
      #1;
      issue(4'h0, AW2'(16'h0010), 32'h0, waits);
      issue(4'h0, AW2'(16'h0040), 32'h0, waits);
      reset_i   = 1'b1;
      exp_q.delete();
      req_valid = 1'b1;
      req_we    = 4'hF;
      req_addr  = AW2'(16'h0010);
      req_wdata = 32'h5555AAAA;
      @(negedge clk);
      check("midrst_clken", 32'(bram_clken), 32'd0);
      check("midrst_bram_we", 32'(bram_we), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      reset_i   = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("postrst_rsp_rdata", rsp_rdata, 32'd0);
      check("postrst_rsp_write", 32'(rsp_write), 32'd0);
      check("postrst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      rdy_mode = 1;
      repeat (8) @(posedge clk);
      #1;
      issue(4'h0, AW2'(16'h0010), 32'h0, waits);
      wait_drain("drain_postrst");

      // Random traffic with random response back-pressure.
      rdy_mode = 2;
      for (int n = 0; n < 400; n++) begin
         rwe   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         raddr = AW2'($urandom_range(0, 63));
         issue(rwe, raddr, $urandom, waits);
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      rdy_mode = 1;
      wait_drain("drain_random");
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
